tt_scan_4: RTL and testbench
============================

TT_SCAN_4 -- requirements
Module: tt_scan_4

Interface
REQ-001 The block SHALL expose parameter SETTLE, default 1, number of clock cycles each input vector is held before F is sampled; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to scan all 16 input vectors.
REQ-005 The block SHALL have port F, input, 1, output of the 4-input combinational function under test.
REQ-006 The block SHALL have ports A, B, C, D, output, 1 each, registered vector driven into the function under test.
REQ-007 The block SHALL have port busy, output, 1, high while a scan is in progress.
REQ-008 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 The block SHALL have port tt, output, 16, captured truth table.
REQ-010 The block SHALL have port ones, output, 5, count of minterms with F=1 (0..16).

Function
REQ-011 Vector index idx SHALL be {A,B,C,D}, A as MSB; tt[idx] SHALL hold F sampled for that vector.
REQ-012 FSM states SHALL be IDLE, APPLY and DONE; busy SHALL be 1 in APPLY and DONE.
REQ-013 IDLE: start=1 at a clock edge SHALL move the FSM to APPLY, set idx=0, clear the settle counter, clear tt to 0 and clear ones to 0.
REQ-014 APPLY: the block SHALL drive A..D from idx and hold them for exactly SETTLE cycles.
REQ-015 APPLY: on the edge that ends the SETTLE-th cycle, the block SHALL write F into tt[idx] and add F to ones.
REQ-016 APPLY: after the sample, idx<15 SHALL increment idx and clear the settle counter; idx=15 SHALL move the FSM to DONE.
REQ-017 DONE: done SHALL be 1 for exactly one cycle, A..D SHALL be 0, and the next edge SHALL return the FSM to IDLE.
REQ-018 Latency: with start sampled at edge 0, samples SHALL occur at edges SETTLE, 2*SETTLE, ..., 16*SETTLE; done SHALL be high from edge 16*SETTLE to edge 16*SETTLE+1.
REQ-019 start SHALL be ignored in APPLY and DONE; no restart and no queuing.
REQ-020 In IDLE, A..D SHALL be 0 and tt and ones SHALL hold the last completed scan result until the next accepted start.
REQ-021 idx SHALL NOT wrap past 15; exactly 16 samples SHALL be taken per scan.
REQ-022 ones SHALL be 5 bits wide so that it saturates nowhere; the value 16 SHALL be representable.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock, force state IDLE, A=B=C=D=0, busy=0, done=0, tt=0, ones=0, idx=0 and settle counter=0.
REQ-024 Reset asserted mid-scan SHALL abort the scan with no done pulse; the partial tt SHALL be discarded (reads 0).
REQ-025 start SHALL be ignored on any edge at which rst_n is 0.

Verification
REQ-026 F tied 0, SETTLE=1, pulse start -> done at edge 16; tt=16'h0000; ones=0.
REQ-027 F tied 1 -> tt=16'hFFFF; ones=16 (5'b10000).
REQ-028 F driven by the product-of-sums (A|B|~D)&(C|~D)&(~A|~D)&(~A|B|C) from A..D -> tt=16'h54D5; ones=8.
REQ-029 SETTLE=3, F=A -> tt=16'hFF00; ones=8; done high exactly at edge 48 for one cycle; each vector held 3 cycles.
REQ-030 Assert rst_n=0 at edge 7 of a scan -> all outputs 0 asynchronously; no done pulse; a new start then produces a full correct scan.
REQ-031 Pulse start again at edges 5 and 16 (DONE cycle) of a SETTLE=1 scan -> both ignored; busy falls at edge 17; tt is unaffected.

Source files
------------

// File: rtl/tt_scan_4_if.sv
// Bus between the truth-table scanner and the 4-input function it probes.
// The scanner takes the slave side; whatever supplies start and F takes the master side.
interface tt_scan_4_if;
   logic        start;
   logic        F;
   logic        A;
   logic        B;
   logic        C;
   logic        D;
   logic        busy;
   logic        done;
   logic [15:0] tt;
   logic [4:0]  ones;

   modport master (
      output start, F,
      input  A, B, C, D, busy, done, tt, ones
   );

   modport slave (
      input  start, F,
      output A, B, C, D, busy, done, tt, ones
   );
endinterface

// File: rtl/tt_scan_4.sv
// Walks {A,B,C,D} through all 16 vectors, holds each for SETTLE cycles,
// and records F for each vector into a truth table and a count of ones.
module tt_scan_4 #(
   parameter int SETTLE = 1
) (
   input logic       clk,
   input logic       rst_n,
   tt_scan_4_if.slave bus
);

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [3:0]  idx_r, idx_s;
   logic [3:0]  cnt_r, cnt_s;
   logic [15:0] tt_r, tt_s;
   logic [4:0]  ones_r, ones_s;
   logic [3:0]  abcd_r, abcd_s;
   logic        busy_r, busy_s;
   logic        done_r, done_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and next-output logic; outputs are registered from these values
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      tt_s    = tt_r;
      ones_s  = ones_r;
      abcd_s  = 4'd0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s = APPLY;
               idx_s   = 4'd0;
               cnt_s   = 4'd0;
               tt_s    = 16'h0000;
               ones_s  = 5'd0;
            end else begin
               state_s = IDLE;
            end
         end
         APPLY: begin
            abcd_s = idx_r;
            if (cnt_r == SETTLE_M1) begin
               tt_s[idx_r] = bus.F;
               ones_s      = ones_r + {4'd0, bus.F};
               // The last vector goes straight to DONE so idx never wraps
               if (idx_r == 4'd15) begin
                  state_s = DONE;
                  abcd_s  = 4'd0;
               end else begin
                  idx_s  = idx_r + 4'd1;
                  cnt_s  = 4'd0;
                  abcd_s = idx_r + 4'd1;
               end
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
            idx_s   = 4'd0;
            cnt_s   = 4'd0;
         end
         default: begin
            state_s = IDLE;
            idx_s   = 4'd0;
            cnt_s   = 4'd0;
         end
      endcase
      busy_s = (state_s != IDLE);
      done_s = (state_s == DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r  <= 4'd0;
         cnt_r  <= 4'd0;
         tt_r   <= 16'h0000;
         ones_r <= 5'd0;
         abcd_r <= 4'd0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         idx_r  <= idx_s;
         cnt_r  <= cnt_s;
         tt_r   <= tt_s;
         ones_r <= ones_s;
         abcd_r <= abcd_s;
         busy_r <= busy_s;
         done_r <= done_s;
      end
   end

   assign bus.A    = abcd_r[3];
   assign bus.B    = abcd_r[2];
   assign bus.C    = abcd_r[1];
   assign bus.D    = abcd_r[0];
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.tt   = tt_r;
   assign bus.ones = ones_r;

endmodule

// File: tb/tb_tt_scan_4.sv
// Directed bench for tt_scan_4: table of whole-scan vectors at SETTLE=1, plus
// hand sequences for SETTLE=3 timing, mid-scan reset and ignored restarts.
module tb_tt_scan_4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   mode  = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   tt_scan_4_if if1();
   tt_scan_4_if if3();

   function automatic logic pos_f(input logic a, input logic b, input logic c, input logic d);
      return (a | b | ~d) & (c | ~d) & (~a | ~d) & (~a | b | c);
   endfunction

   // Function under test for the SETTLE=1 instance: 0 = const 0, 1 = const 1, 2 = POS expression
   assign if1.F = (mode == 0) ? 1'b0 :
                  (mode == 1) ? 1'b1 : pos_f(if1.A, if1.B, if1.C, if1.D);
   assign if3.F = if3.A;

   tt_scan_4 #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   tt_scan_4 #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   typedef struct {
      string       name;
      int          mode;
      logic [15:0] tt;
      logic [4:0]  ones;
   } vec_t;

   vec_t vecs[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start a scan on the SETTLE=1 instance; n = edge (after start edge) at which done is seen
   task automatic scan1(output int n);
      @(negedge clk) if1.start = 1'b1;
      @(negedge clk) if1.start = 1'b0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (if1.done) break;
      end
   endtask

   initial begin
      int n;
      if1.start = 1'b0;
      if3.start = 1'b0;

      vecs[0] = '{name: "f_zero", mode: 0, tt: 16'h0000, ones: 5'd0};
      vecs[1] = '{name: "f_one",  mode: 1, tt: 16'hFFFF, ones: 5'd16};
      vecs[2] = '{name: "f_pos",  mode: 2, tt: 16'h54D5, ones: 5'd8};

      #1;
      chk("rst_tt",   if1.tt, 16'h0000);
      chk("rst_ones", if1.ones, 5'd0);
      chk("rst_busy", if1.busy, 1'b0);
      chk("rst_abcd", {if1.A, if1.B, if1.C, if1.D}, 4'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) begin
         mode = vecs[i].mode;
         scan1(n);
         chk({vecs[i].name, "_done_edge"}, n, 16);
         chk({vecs[i].name, "_tt"}, if1.tt, vecs[i].tt);
         chk({vecs[i].name, "_ones"}, if1.ones, vecs[i].ones);
         @(negedge clk);
         chk({vecs[i].name, "_done_fall"}, if1.done, 1'b0);
         chk({vecs[i].name, "_busy_fall"}, if1.busy, 1'b0);
      end

      // SETTLE=3 with F=A: each vector held three cycles, done at edge 48 only
      @(negedge clk) if3.start = 1'b1;
      @(negedge clk) if3.start = 1'b0;
      for (int k = 1; k <= 49; k++) begin
         @(negedge clk);
         if (k < 48) begin
            chk("s3_vec", {if3.A, if3.B, if3.C, if3.D}, k / 3);
            chk("s3_done_early", if3.done, 1'b0);
         end else if (k == 48) begin
            chk("s3_done_48", if3.done, 1'b1);
            chk("s3_busy_48", if3.busy, 1'b1);
            chk("s3_vec_done", {if3.A, if3.B, if3.C, if3.D}, 4'h0);
         end else begin
            chk("s3_done_49", if3.done, 1'b0);
            chk("s3_busy_49", if3.busy, 1'b0);
         end
      end
      chk("s3_tt", if3.tt, 16'hFF00);
      chk("s3_ones", if3.ones, 5'd8);

      // Restart attempts at edge 5 and edge 16 must be ignored
      mode = 1;
      @(negedge clk) if1.start = 1'b1;
      @(negedge clk) if1.start = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 15) chk("rs_busy_15", if1.busy, 1'b1);
         if (k == 16) chk("rs_done_16", if1.done, 1'b1);
         if (k == 17) begin
            chk("rs_busy_17", if1.busy, 1'b0);
            chk("rs_done_17", if1.done, 1'b0);
         end
         if (k == 18) chk("rs_busy_18", if1.busy, 1'b0);
         if1.start = (k == 4 || k == 15) ? 1'b1 : 1'b0;
      end
      chk("rs_tt", if1.tt, 16'hFFFF);
      chk("rs_ones", if1.ones, 5'd16);

      // Reset just after edge 7 of a scan, then a clean full scan
      mode = 1;
      @(negedge clk) if1.start = 1'b1;
      @(negedge clk) if1.start = 1'b0;
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2;
      chk("pre_rst_tt", if1.tt, 16'h007F);
      chk("pre_rst_ones", if1.ones, 5'd7);
      rst_n = 1'b0;
      #1;
      chk("arst_tt", if1.tt, 16'h0000);
      chk("arst_ones", if1.ones, 5'd0);
      chk("arst_busy", if1.busy, 1'b0);
      chk("arst_done", if1.done, 1'b0);
      chk("arst_abcd", {if1.A, if1.B, if1.C, if1.D}, 4'h0);
      @(negedge clk) if1.start = 1'b1;
      @(negedge clk) if1.start = 1'b0;
      chk("rst_start_ign", if1.busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", if1.busy, 1'b0);
      mode = 2;
      scan1(n);
      chk("post_rst_done_edge", n, 16);
      chk("post_rst_tt", if1.tt, 16'h54D5);
      chk("post_rst_ones", if1.ones, 5'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
